// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch (I) and load/store (D) onto one single-port memory, one access per MEM_LAT+3 cycles.
// Optional ARB_RR_EN: round-robin between contending I and D; otherwise fixed priority, D over I.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                halt,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic                r_gnt_d;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [BE_W-1:0]     r_be;
  logic [DATA_W-1:0]   r_i_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                w_el_d;
  logic                w_el_i;
  logic                w_pick_d;
  logic                w_grant;

  assign w_el_d  = d_read | d_write;
  assign w_el_i  = i_req & ~halt;
  assign w_grant = (r_state == IDLE) && (w_el_d || w_el_i);

`ifdef ARB_RR_EN
  // Pointer names the side that wins the next contended grant.
  logic r_rr_d_next;

  assign w_pick_d = w_el_d & (~w_el_i | r_rr_d_next);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_d_next <= 1'b1;
    end else if (w_grant && w_el_d && w_el_i) begin
      r_rr_d_next <= ~r_rr_d_next;
    end
  end
`else
  assign w_pick_d = w_el_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_el_d || w_el_i) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (r_cnt == 4'd1) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_gnt_d   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_gnt_d <= w_pick_d;
            if (w_pick_d) begin
              // A simultaneous read+write is served as a write.
              r_addr  <= d_addr;
              r_we    <= d_write;
              r_wdata <= d_wdata;
              r_be    <= d_write ? d_be : {BE_W{1'b1}};
            end else begin
              r_addr  <= i_addr;
              r_we    <= 1'b0;
              r_wdata <= '0;
              r_be    <= {BE_W{1'b1}};
            end
          end
        end
        ISSUE: r_cnt <= 4'(MEM_LAT);
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1 && !r_we) begin
            if (r_gnt_d) r_d_rdata <= mem_rdata;
            else         r_i_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_en    = (r_state == ISSUE);
  assign mem_we    = (r_state == ISSUE) && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_be    = r_be;
  assign i_ack     = (r_state == DONE) && !r_gnt_d;
  assign d_ack     = (r_state == DONE) && r_gnt_d;
  assign busy      = (r_state != IDLE);
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;

endmodule
